gyro_drx_deser: RTL
===================

Name: gyro_drx_deser

Overview:
- Controller-side receiver for the HSI return link: deserializes DRX, the ASIC-to-controller data line, into 32-bit words, framed by the controller's own DSYNC pulse.
- Complements the existing DTX serializer on the same MCK domain.
- A programmable sample delay absorbs board and pad round-trip skew; tens of ns are typical.
- Output words go through a valid/ready handshake into the RX FIFO / AXI capture path.

Parameters:
- WORDS_PER_FRAME, 4, number of 32-bit words per DSYNC frame (1..16).
- SKEW_W, 3, width of the skew_cyc configuration field.
- FCNT_W, 16, width of the frame counter.

Ports:
- MCK  input  1  master clock, 48 MHz; all logic on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- en  input  1  receiver enable; low forces IDLE.
- DSYNC  input  1  frame sync pulse, one MCK cycle wide, same as driven to the ASIC.
- DRX  input  1  serial data from the ASIC, MSB first.
- skew_cyc  input  SKEW_W  extra MCK cycles between DSYNC and the first bit sample.
- rx_data  output  32  received word.
- rx_last  output  1  marks the final word of a frame.
- rx_valid  output  1  rx_data/rx_last valid.
- rx_ready  input  1  downstream accepts the word when rx_valid && rx_ready.
- frame_cnt  output  FCNT_W  count of completed frames.
- sync_err  output  1  sticky: DSYNC arrived mid-frame.
- ovf_err  output  1  sticky: word completed while the holding register was still full.
- clr_err  input  1  synchronous clear of sync_err/ovf_err.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (RST_N low, async): all outputs 0; FSM to IDLE; shift register, bit and word counters cleared.
- DRX and DSYNC are each registered once at the input.
  - Timing reference: cycle 0 is the MCK edge at which DSYNC is sampled high.
  - Bit k of the frame (k = 0..32*WORDS_PER_FRAME-1) is the DRX value at edge 1+skew_cyc+k.
- FSM states:
  - IDLE: on DSYNC && en, latch skew_cyc and go to SKEW if skew_cyc != 0, else SHIFT.
  - SKEW: down-counter; go to SHIFT when it expires.
  - SHIFT: shift in 1 bit per cycle, MSB first; bit counter 0..31 and word counter 0..WORDS_PER_FRAME-1.
  - End of frame: after the last bit, frame_cnt increments (wraps modulo 2^FCNT_W) and the FSM returns to IDLE.
  - A DSYNC in the same cycle as the last bit is accepted as the next frame start.
- Word output:
  - At bit 31 the word is transferred to the holding register.
  - rx_valid rises on the following edge.
  - rx_last is set for word index WORDS_PER_FRAME-1.
  - rx_valid stays high until a handshake occurs.
  - If the handshake and a new word completion fall in the same cycle, the new word loads and rx_valid stays high.
- Overflow: a completing word while rx_valid && !rx_ready is dropped; the held word is kept and ovf_err is set.
- DSYNC in SKEW or SHIFT (other than on the last-bit cycle):
  - set sync_err;
  - discard the partial word (already-emitted words stay);
  - restart as from cycle 0 with the newly latched skew_cyc;
  - frame_cnt is not incremented.
- en deasserted mid-frame: return to IDLE next edge, partial word discarded, no error. The holding register is unaffected.
- clr_err clears the sticky flags. A set event in the same cycle wins.
- skew_cyc changes take effect only at the next frame start.

Optional Feature:
- Macro: GYRO_DRX_PARITY_EN.
- When defined:
  - Each 32-bit word is followed by 1 even-parity bit, so the frame is 33*WORDS_PER_FRAME bits.
  - An extra output rx_perr (1 bit) accompanies rx_data with the same valid/handshake timing; it is high when parity mismatches.
  - rx_perr resets to 0.
- When undefined: no parity bits; 32 bits per word; the rx_perr port does not exist.

Test Plan:
- Basic frame: WORDS_PER_FRAME=4, skew_cyc=0, DRX carries 0xDEADBEEF, 0x12345678, 0x00000000, 0xFFFFFFFF starting edge 1 after DSYNC, rx_ready=1 -> four rx_valid pulses with exactly those words; rx_last only on the 4th; frame_cnt=1.
- Skew: hsi loopback model with 24 ns DRX delay and skew_cyc=2 -> words match the DTX payload; with skew_cyc=0 words are shifted by 2 bits (mismatch detected).
- Backpressure: rx_ready held 0 for 40 cycles after word 0 -> word 0 held unchanged; word 1 dropped; ovf_err=1; clr_err pulse -> ovf_err=0.
- Mid-frame DSYNC: second DSYNC at bit 50 of frame -> sync_err=1; word 0 still delivered; next 4 words come from the new frame; frame_cnt increments once only.
- Async reset mid-SHIFT: RST_N low for 3 cycles at bit 20 -> all outputs 0 immediately; busy=0; the next DSYNC frame is received correctly.
- With GYRO_DRX_PARITY_EN: word 0xA5A5A5A5 followed by a parity bit of 1 -> rx_perr=1; with parity bit 0 -> rx_perr=0.

Source files
------------

// File: rtl/gyro_drx_deser.sv
// HSI return-link receiver: deserializes DRX into 32-bit words framed by the controller's DSYNC pulse.
// Define GYRO_DRX_PARITY_EN to expect an even-parity bit after every word and expose rx_perr.
module gyro_drx_deser #(
    parameter int WORDS_PER_FRAME = 4,
    parameter int SKEW_W          = 3,
    parameter int FCNT_W          = 16
) (
    input  logic              MCK,
    input  logic              RST_N,
    input  logic              en,
    input  logic              DSYNC,
    input  logic              DRX,
    input  logic [SKEW_W-1:0] skew_cyc,
    output logic [31:0]       rx_data,
    output logic              rx_last,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              sync_err,
    output logic              ovf_err,
    input  logic              clr_err,
    output logic              busy
`ifdef GYRO_DRX_PARITY_EN
    ,
    output logic              rx_perr
`endif
);

`ifdef GYRO_DRX_PARITY_EN
    localparam int WORD_BITS = 33;
`else
    localparam int WORD_BITS = 32;
`endif
    localparam int WCNT_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam logic [5:0]        LAST_BIT  = 6'(WORD_BITS - 1);
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS_PER_FRAME - 1);

    typedef enum logic [1:0] {IDLE, SKEW, SHIFT} state_t;

    state_t            state, state_nxt;
    logic              dsync_q, drx_q;
    logic [SKEW_W-1:0] skew_left;
    logic [5:0]        bit_cnt;
    logic [WCNT_W-1:0] word_cnt;
    logic [31:0]       shreg;
    logic              start, sync_set, word_done, last_bit;
    logic [31:0]       word_data;

`ifdef GYRO_DRX_PARITY_EN
    logic word_perr;
    assign word_data = shreg;
    assign word_perr = ^{shreg, drx_q};
`else
    assign word_data = {shreg[30:0], drx_q};
`endif

    assign busy = (state != IDLE);

    // A DSYNC on the final bit is a clean back-to-back start; anywhere else it aborts the frame.
    always_comb begin
        last_bit  = (state == SHIFT) && (bit_cnt == LAST_BIT) && (word_cnt == LAST_WORD);
        start     = 1'b0;
        sync_set  = 1'b0;
        word_done = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: start = dsync_q && en;
            SKEW: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (dsync_q) begin
                    start    = 1'b1;
                    sync_set = 1'b1;
                end else if (skew_left == SKEW_W'(1)) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else begin
                    word_done = (bit_cnt == LAST_BIT) && (!dsync_q || last_bit);
                    if (dsync_q) begin
                        start    = 1'b1;
                        sync_set = !last_bit;
                    end else if (last_bit) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (start) state_nxt = (skew_cyc != '0) ? SKEW : SHIFT;
    end

    always_ff @(posedge MCK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            dsync_q   <= 1'b0;
            drx_q     <= 1'b0;
            skew_left <= '0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            shreg     <= '0;
        end else begin
            state   <= state_nxt;
            dsync_q <= DSYNC;
            drx_q   <= DRX;
            if (start) begin
                skew_left <= skew_cyc;
                bit_cnt   <= '0;
                word_cnt  <= '0;
            end else if (state == SKEW) begin
                skew_left <= skew_left - SKEW_W'(1);
            end else if (state_nxt == SHIFT) begin
                shreg <= {shreg[30:0], drx_q};
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt  <= '0;
                    word_cnt <= word_cnt + WCNT_W'(1);
                end else begin
                    bit_cnt <= bit_cnt + 6'd1;
                end
            end else begin
                bit_cnt  <= '0;
                word_cnt <= '0;
            end
        end
    end

    // Holding register: a completed word is dropped rather than overwriting an unaccepted one.
    always_ff @(posedge MCK or negedge RST_N) begin
        if (!RST_N) begin
            rx_data   <= '0;
            rx_last   <= 1'b0;
            rx_valid  <= 1'b0;
            frame_cnt <= '0;
            sync_err  <= 1'b0;
            ovf_err   <= 1'b0;
`ifdef GYRO_DRX_PARITY_EN
            rx_perr   <= 1'b0;
`endif
        end else begin
            if (word_done) begin
                if (!(rx_valid && !rx_ready)) begin
                    rx_data  <= word_data;
                    rx_last  <= (word_cnt == LAST_WORD);
                    rx_valid <= 1'b1;
`ifdef GYRO_DRX_PARITY_EN
                    rx_perr  <= word_perr;
`endif
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (word_done && last_bit) frame_cnt <= frame_cnt + FCNT_W'(1);
            sync_err <= sync_set || (sync_err && !clr_err);
            ovf_err  <= (word_done && rx_valid && !rx_ready) || (ovf_err && !clr_err);
        end
    end

endmodule
